// File: rtl/flash_ctrl_pkg.sv
// Shared definitions for the flash sense-amp read sequencer.
//   state_t     : sequencer states IDLE -> PRE -> SNS -> OUT -> RESP
//   DEF_*_CYC   : default phase lengths in clock cycles
//   grp_onehot  : 2-bit output-group index to 4-bit one-hot enable
package flash_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SNS  = 3'd2,
    OUT  = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam int DEF_PRE_CYC = 4;
  localparam int DEF_SNS_CYC = 8;
  localparam int DEF_OUT_CYC = 2;

  function automatic logic [3:0] grp_onehot(input logic [1:0] grp);
    return 4'b0001 << grp;
  endfunction

endpackage

// File: rtl/flash_phase_timer.sv
// Loadable 8-bit down-counter that times one sequencer phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load len into the counter (takes priority over counting)
//   len        : phase length minus one
//   done       : counter is at zero, i.e. this is the last cycle of the phase
module flash_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] len,
  output logic       done
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len;
    end else if (cnt != '0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/flash_sense_ctrl.sv
// Read sequencer for the 8x8 flash array sense amplifiers.
// Runs precharge (sen1), sense (sen1+sen2) and output-enable (sen2+out_en)
// phases, captures the array's out bus and returns it on a valid/ready channel.
//   wb_clk_i, wb_rst_ni        : clock, asynchronous active-low reset
//   req_valid/req_ready/req_grp: read request with output-group select
//   rsp_valid/rsp_ready/rsp_data: captured byte response
//   sen1, sen2, out_en         : array sense controls (all registered)
//   sa_out                     : array digital output bus
//   busy                       : sequencer not in IDLE
module flash_sense_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int PRE_CYC = DEF_PRE_CYC,
  parameter int SNS_CYC = DEF_SNS_CYC,
  parameter int OUT_CYC = DEF_OUT_CYC
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_grp,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       sen1,
  output logic       sen2,
  output logic [3:0] out_en,
  input  logic [7:0] sa_out,
  output logic       busy
);

  if (PRE_CYC < 1 || PRE_CYC > 255) begin : g_bad_pre
    $error("PRE_CYC must be in 1..255");
  end
  if (SNS_CYC < 1 || SNS_CYC > 255) begin : g_bad_sns
    $error("SNS_CYC must be in 1..255");
  end
  if (OUT_CYC < 1 || OUT_CYC > 255) begin : g_bad_out
    $error("OUT_CYC must be in 1..255");
  end

  localparam logic [7:0] PRE_LEN = 8'(PRE_CYC - 1);
  localparam logic [7:0] SNS_LEN = 8'(SNS_CYC - 1);
  localparam logic [7:0] OUT_LEN = 8'(OUT_CYC - 1);

  state_t     state;
  logic [1:0] grp;
  logic       tmr_load;
  logic [7:0] tmr_len;
  logic       tmr_done;

  // Timer is reloaded on the same edge that enters the next phase, so the
  // first cycle of a phase already sees len and done marks its last cycle.
  always_comb begin
    tmr_load = 1'b0;
    tmr_len  = '0;
    case (state)
      IDLE: if (req_valid && req_ready) begin
        tmr_load = 1'b1;
        tmr_len  = PRE_LEN;
      end
      PRE: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_len  = SNS_LEN;
      end
      SNS: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_len  = OUT_LEN;
      end
      default: ;
    endcase
  end

  flash_phase_timer u_timer (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .load  (tmr_load),
    .len   (tmr_len),
    .done  (tmr_done)
  );

  // Outputs are set on the transition into each state so that every array
  // control comes straight from a flop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      grp       <= '0;
      sen1      <= 1'b0;
      sen2      <= 1'b0;
      out_en    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid && req_ready) begin
          state     <= PRE;
          grp       <= req_grp;
          sen1      <= 1'b1;
          req_ready <= 1'b0;
          busy      <= 1'b1;
        end
        PRE: if (tmr_done) begin
          state <= SNS;
          sen2  <= 1'b1;
        end
        SNS: if (tmr_done) begin
          // sen1 falls on the same edge out_en rises; never overlapping.
          state  <= OUT;
          sen1   <= 1'b0;
          out_en <= grp_onehot(grp);
        end
        OUT: if (tmr_done) begin
          state     <= RESP;
          sen2      <= 1'b0;
          out_en    <= '0;
          rsp_valid <= 1'b1;
          rsp_data  <= sa_out;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          sen1      <= 1'b0;
          sen2      <= 1'b0;
          out_en    <= '0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sense_ctrl.sv
// Directed bench for flash_sense_ctrl: default-timing instance plus a
// single-cycle-phase instance for back-to-back throughput.
module tb_flash_sense_ctrl;

  logic       clk;
  logic       rst_n;

  logic       req_valid, req_ready, rsp_valid, rsp_ready, sen1, sen2, busy;
  logic [1:0] req_grp;
  logic [7:0] rsp_data, sa_out;
  logic [3:0] out_en;

  logic       req_valid_f, req_ready_f, rsp_valid_f, rsp_ready_f, sen1_f, sen2_f, busy_f;
  logic [1:0] req_grp_f;
  logic [7:0] rsp_data_f, sa_out_f;
  logic [3:0] out_en_f;

  int total = 0;
  int bad   = 0;

  flash_sense_ctrl #(.PRE_CYC(4), .SNS_CYC(8), .OUT_CYC(2)) dut (
    .wb_clk_i (clk),       .wb_rst_ni (rst_n),
    .req_valid(req_valid), .req_ready (req_ready), .req_grp (req_grp),
    .rsp_valid(rsp_valid), .rsp_ready (rsp_ready), .rsp_data(rsp_data),
    .sen1     (sen1),      .sen2      (sen2),      .out_en  (out_en),
    .sa_out   (sa_out),    .busy      (busy)
  );

  flash_sense_ctrl #(.PRE_CYC(1), .SNS_CYC(1), .OUT_CYC(1)) dut_f (
    .wb_clk_i (clk),         .wb_rst_ni (rst_n),
    .req_valid(req_valid_f), .req_ready (req_ready_f), .req_grp (req_grp_f),
    .rsp_valid(rsp_valid_f), .rsp_ready (rsp_ready_f), .rsp_data(rsp_data_f),
    .sen1     (sen1_f),      .sen2      (sen2_f),      .out_en  (out_en_f),
    .sa_out   (sa_out_f),    .busy      (busy_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety monitor on both instances: out_en never overlaps sen1, always one-hot or zero.
  always @(negedge clk) begin
    total++;
    if ((sen1 && out_en != 4'b0) || !$onehot0(out_en)) begin
      bad++;
      $display("FAIL mon_outen: sen1=%b out_en=%b required out_en one-hot/zero and zero while sen1", sen1, out_en);
    end
    total++;
    if ((sen1_f && out_en_f != 4'b0) || !$onehot0(out_en_f)) begin
      bad++;
      $display("FAIL mon_outen_f: sen1=%b out_en=%b required out_en one-hot/zero and zero while sen1", sen1_f, out_en_f);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1; req_grp = 2'd1; rsp_ready = 1'b1; sa_out = 8'hFF;
    req_valid_f = 1'b0; req_grp_f = 2'd0; rsp_ready_f = 1'b1; sa_out_f = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (sen1 !== 1'b0) begin bad++; $display("FAIL rst_sen1: got %b want 0", sen1); end
    total++; if (sen2 !== 1'b0) begin bad++; $display("FAIL rst_sen2: got %b want 0", sen2); end
    total++; if (out_en !== 4'b0000) begin bad++; $display("FAIL rst_out_en: got %b want 0000", out_en); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_no_accept: busy got %b want 0", busy); end
  endtask

  task automatic test_single_read();
    logic exp_s1, exp_s2, exp_rv;
    logic [3:0] exp_oe;
    req_valid = 1'b1; req_grp = 2'd2; sa_out = 8'hA5; rsp_ready = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      exp_s1 = (c <= 12);
      exp_s2 = (c >= 5 && c <= 14);
      exp_oe = (c == 13 || c == 14) ? 4'b0100 : 4'b0000;
      exp_rv = (c == 15);
      total++; if (sen1 !== exp_s1) begin bad++; $display("FAIL rd_sen1 c%0d: got %b want %b", c, sen1, exp_s1); end
      total++; if (sen2 !== exp_s2) begin bad++; $display("FAIL rd_sen2 c%0d: got %b want %b", c, sen2, exp_s2); end
      total++; if (out_en !== exp_oe) begin bad++; $display("FAIL rd_out_en c%0d: got %b want %b", c, out_en, exp_oe); end
      total++; if (rsp_valid !== exp_rv) begin bad++; $display("FAIL rd_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rv); end
      total++; if (busy !== (c <= 15)) begin bad++; $display("FAIL rd_busy c%0d: got %b want %b", c, busy, (c <= 15)); end
      total++; if (req_ready !== (c == 16)) begin bad++; $display("FAIL rd_req_ready c%0d: got %b want %b", c, req_ready, (c == 16)); end
      if (c == 15) begin
        total++; if (rsp_data !== 8'hA5) begin bad++; $display("FAIL rd_data: got %h want a5", rsp_data); end
      end
    end
  endtask

  task automatic test_hold_off();
    int c;
    req_valid = 1'b1; req_grp = 2'd1; sa_out = 8'hA5; rsp_ready = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (rsp_valid !== 1'b1 && c < 30);
    total++; if (c != 15) begin bad++; $display("FAIL hold_latency: rsp_valid at cycle %0d want 15", c); end
    sa_out = 8'h3C; req_grp = 2'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (rsp_data !== 8'hA5) begin bad++; $display("FAIL hold_data i%0d: got %h want a5", i, rsp_data); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hold_req_ready i%0d: got %b want 0", i, req_ready); end
      total++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL hold_state i%0d: valid=%b busy=%b want 1/1", i, rsp_valid, busy); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release: busy=%b ready=%b valid=%b want 0/1/0", busy, req_ready, rsp_valid);
    end
    @(negedge clk);
    total++; if (busy !== 1'b1 || sen1 !== 1'b1) begin bad++; $display("FAIL hold_next_accept: busy=%b sen1=%b want 1/1", busy, sen1); end
    req_valid = 1'b0;
    for (c = 2; c <= 15; c++) begin
      @(negedge clk);
      if (c == 13) begin
        total++; if (out_en !== 4'b1000) begin bad++; $display("FAIL hold2_out_en: got %b want 1000", out_en); end
      end
    end
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C) begin
      bad++; $display("FAIL hold2_rsp: valid=%b data=%h want 1/3c", rsp_valid, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    req_valid = 1'b1; req_grp = 2'd0; sa_out = 8'h5A; rsp_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
    end
    total++; if (sen1 !== 1'b1 || sen2 !== 1'b1) begin bad++; $display("FAIL mrst_pre: sen1=%b sen2=%b want 1/1", sen1, sen2); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (sen1 !== 1'b0 || sen2 !== 1'b0 || out_en !== 4'b0) begin
      bad++; $display("FAIL mrst_async: sen1=%b sen2=%b out_en=%b want 0/0/0000", sen1, sen2, out_en);
    end
    total++; if (busy !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL mrst_idle: busy=%b ready=%b want 0/1", busy, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (c == 13) begin
        total++; if (out_en !== 4'b0001) begin bad++; $display("FAIL mrst_out_en: got %b want 0001", out_en); end
      end
      if (c == 14) begin
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mrst_early: rsp_valid got %b want 0", rsp_valid); end
      end
      if (c == 15) begin
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A) begin
          bad++; $display("FAIL mrst_rsp: valid=%b data=%h want 1/5a", rsp_valid, rsp_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k, ph;
    logic [3:0] exp_oe;
    logic [7:0] exp_d;
    req_valid_f = 1'b1; req_grp_f = 2'd0; rsp_ready_f = 1'b1; sa_out_f = 8'h10;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      k  = (c - 1) / 5;
      ph = (c - 1) % 5 + 1;
      if (ph == 1) begin
        sa_out_f = 8'h10 + 8'(k);
        if (k < 3) req_grp_f = 2'(k + 1);
        else req_valid_f = 1'b0;
      end
      exp_oe = (ph == 3) ? 4'(1 << k) : 4'b0000;
      exp_d  = 8'h10 + 8'(k);
      total++; if (out_en_f !== exp_oe) begin bad++; $display("FAIL b2b_out_en c%0d: got %b want %b", c, out_en_f, exp_oe); end
      total++; if (rsp_valid_f !== (ph == 4)) begin bad++; $display("FAIL b2b_rsp_valid c%0d: got %b want %b", c, rsp_valid_f, (ph == 4)); end
      total++; if (busy_f !== (ph != 5)) begin bad++; $display("FAIL b2b_busy c%0d: got %b want %b", c, busy_f, (ph != 5)); end
      total++; if (sen1_f !== (ph <= 2)) begin bad++; $display("FAIL b2b_sen1 c%0d: got %b want %b", c, sen1_f, (ph <= 2)); end
      if (ph == 4) begin
        total++; if (rsp_data_f !== exp_d) begin bad++; $display("FAIL b2b_data c%0d: got %h want %h", c, rsp_data_f, exp_d); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_hold_off();
    test_mid_reset();
    test_back_to_back();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_sense_ctrl.md
# flash_sense_ctrl

Read sequencer that drives the sense-amplifier controls of the 8x8 flash array: `sen1`, `sen2` and the 4-bit `out_en` group select. It captures the array's 8-bit digital `out` bus and returns the byte over a valid/ready response channel. It sits directly upstream of the array's sense inputs and downstream of its digital outputs, and is clocked from the Wishbone clock inside the user project wrapper.

## Interface
Parameters:
- `PRE_CYC`, default 4: precharge phase length in cycles, range 1..255.
- `SNS_CYC`, default 8: sense phase length in cycles, range 1..255.
- `OUT_CYC`, default 2: output-enable phase length in cycles, range 1..255.

Ports:
- `wb_clk_i` in 1: the only clock.
- `wb_rst_ni` in 1: asynchronous, active-low reset.
- `req_valid` in 1: read request.
- `req_ready` out 1: request accepted on a cycle where `req_valid & req_ready`.
- `req_grp` in 2: output group to enable, decoded one-hot onto `out_en`.
- `rsp_valid` out 1: captured byte available.
- `rsp_ready` in 1: consumer accepts the byte.
- `rsp_data` out 8: captured byte.
- `sen1` out 1: sense-amp stage-1 enable, to the array.
- `sen2` out 1: sense-amp stage-2 enable, to the array.
- `out_en` out 4: one-hot output-group enable, to the array.
- `sa_out` in 8: the array's `out` bus.
- `busy` out 1: high in any state other than IDLE.

## Operation
- The FSM has five states: IDLE → PRE → SNS → OUT → RESP → IDLE.
- IDLE:
  - `req_ready`=1.
  - On accept, latch `req_grp` and go to PRE.
- PRE: `sen1`=1, `sen2`=0, `out_en`=0 for `PRE_CYC` cycles.
- SNS: `sen1`=1, `sen2`=1, `out_en`=0 for `SNS_CYC` cycles.
- OUT:
  - `sen1`=0, `sen2`=1, `out_en`=1<<grp for `OUT_CYC` cycles.
  - `sa_out` is registered into `rsp_data` at the clock edge that ends the last OUT cycle.
- RESP:
  - All array controls are 0 and `rsp_valid`=1.
  - `rsp_data` holds stable until `rsp_ready`, then the FSM returns to IDLE.
- `req_ready` is 0 in every state except IDLE. A request presented while busy is held off. It is never dropped and never queued.
- A response handshake does not accept a new request in the same cycle. The earliest accept is the following cycle, in IDLE.
- A single down-counter, 8 bits wide, is loaded with N-1 on each phase entry. The phase exits when the counter reaches 0.
- `out_en` must never be nonzero while `sen1`=1.
- `sen1`, `sen2`, `out_en`, `rsp_valid`, `rsp_data`, `req_ready` and `busy` are all driven from flops, so the analog side never sees glitches.
- Reset may be asserted in any state, including mid-phase. It immediately forces IDLE and deasserts every array control.

## Timing
- Reset values:
  - `sen1`=0, `sen2`=0, `out_en`=4'b0000.
  - `rsp_valid`=0, `rsp_data`=8'h00.
  - `busy`=0, `req_ready`=1 (IDLE).
- Call the accept edge E0. PRE occupies cycles 1..P, SNS occupies P+1..P+S, and OUT occupies P+S+1..P+S+O. `rsp_valid` rises in cycle P+S+O+1.
- With default parameters, `rsp_valid` is first high in cycle 15 after E0.
- Back-to-back throughput is P+S+O+2 cycles per read when `rsp_ready` is held at 1. With defaults that is 16 cycles.
- `rsp_ready` already high on the first RESP cycle gives a 1-cycle RESP.
- Phase boundaries switch controls at clock edges only. The handoff from PRE to SNS raises `sen2` while `sen1` stays high; the handoff from SNS to OUT drops `sen1` and raises `out_en` on the same edge.

## Structure
- Shared package `flash_ctrl_pkg` holds:
  - the state enum (IDLE, PRE, SNS, OUT, RESP);
  - the default phase constants;
  - a `grp_onehot` decode function.
- Sub-module `flash_phase_timer`: loadable 8-bit down-counter with `load`, `len` and `done` ports. It is instantiated once.
- Elaboration check: each `*_CYC` parameter must be between 1 and 255; any other value is an error.

## Test plan
- Reset with `req_valid`=1 → all outputs at their reset values and no accept until `wb_rst_ni`=1.
- Defaults, `req_grp`=2, `sa_out`=8'hA5, `rsp_ready`=1:
  - `sen1` high in cycles 1-12, `sen2` high in cycles 5-14, `out_en`=4'b0100 in cycles 13-14;
  - `rsp_valid` high in cycle 15 with `rsp_data`=8'hA5.
- Hold `rsp_ready`=0 for 10 cycles while changing `sa_out` to 8'h3C → `rsp_data` stays 8'hA5, `req_ready` stays 0, and a second `req_valid` is not accepted.
- Assert reset during SNS (cycle 7) → `sen1`, `sen2` and `out_en` drop to 0 with no clock edge, and the next read completes normally.
- PRE=SNS=OUT=1 with four back-to-back reads, groups 0..3 → one response every 5 cycles with `out_en` 0001/0010/0100/1000 in order.
- Assertion monitor over all tests → `out_en`≠0 never coincides with `sen1`=1, and `out_en` is always one-hot or zero.
